// File: rtl/clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_pkg
// Shared definitions for the programmable clock-enable generator.
//   mode_t        2-bit channel mode encoding (HALT / RUN / STEP / reserved)
//   WR_SEL_*      meaning of the write-select bit on the config port
//   ch_width()    width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package clk_gen_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HALT = 2'b00;
  localparam mode_t MODE_RUN  = 2'b01;
  localparam mode_t MODE_STEP = 2'b10;
  localparam mode_t MODE_RSVD = 2'b11;

  localparam logic WR_SEL_DIV  = 1'b0;
  localparam logic WR_SEL_MODE = 1'b1;

  // A single-channel build still needs a one-bit address port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One channel of the clock-enable generator: divide counter, shadow divisor,
// mode register, step edge detector, and the registered tick/square outputs.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   wr_en        config write addressed to this channel (one cycle)
//   wr_sel       0 = divisor write, 1 = mode write
//   wr_data      divisor value, or mode in [1:0]
//   step         step request (already synchronised)
//   tick         one-cycle enable strobe
//   square       toggles on every tick
//   running      high while the channel is in RUN
// -----------------------------------------------------------------------------
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int                   DIV_WIDTH   = 32,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(8_000_000),
  parameter mode_t                RESET_MODE  = MODE_RUN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [DIV_WIDTH-1:0] wr_data,
  input  logic                 step,
  output logic                 tick,
  output logic                 square,
  output logic                 running
);

  logic [DIV_WIDTH-1:0] cnt, cnt_next;
  logic [DIV_WIDTH-1:0] div_active, div_active_next;
  logic [DIV_WIDTH-1:0] div_shadow, div_shadow_next;
  logic [DIV_WIDTH-1:0] last_count;
  mode_t                mode, mode_next, new_mode;
  logic                 step_q;
  logic                 tick_next;
  logic                 wrap, step_rise, div_wr, mode_change;

  // Next-state logic. The mode decides what the counter does this cycle; a
  // divisor write then overrides the divisor path, and a mode change is
  // applied last so it can clear the counter and, when entering a halted
  // mode, cancel a tick that would otherwise be emitted on this edge.
  // A divisor of 0 is treated as 1 by wrapping whenever the counter is 0.
  always_comb begin
    last_count      = (div_active == '0) ? '0 : div_active - DIV_WIDTH'(1);
    wrap            = (mode == MODE_RUN) && (cnt == last_count);
    step_rise       = step && !step_q;
    new_mode        = mode_t'(wr_data[1:0]);
    div_wr          = wr_en && (wr_sel == WR_SEL_DIV);
    mode_change     = wr_en && (wr_sel == WR_SEL_MODE) && (new_mode != mode);

    cnt_next        = cnt;
    div_active_next = div_active;
    div_shadow_next = div_shadow;
    mode_next       = mode;
    tick_next       = 1'b0;

    case (mode)
      MODE_RUN: begin
        if (wrap) begin
          cnt_next        = '0;
          tick_next       = 1'b1;
          div_active_next = div_wr ? wr_data : div_shadow;
        end else begin
          cnt_next = cnt + DIV_WIDTH'(1);
        end
      end
      MODE_STEP: begin
        cnt_next  = '0;
        tick_next = step_rise;
      end
      default: begin
        cnt_next = '0;
      end
    endcase

    // While running, a new divisor waits in the shadow until the next wrap so
    // the period in progress completes unchanged. Otherwise it applies at once.
    if (div_wr) begin
      div_shadow_next = wr_data;
      if (mode != MODE_RUN) begin
        div_active_next = wr_data;
        cnt_next        = '0;
      end
    end

    if (mode_change) begin
      mode_next = new_mode;
      cnt_next  = '0;
      if ((new_mode == MODE_HALT) || (new_mode == MODE_RSVD)) begin
        tick_next = 1'b0;
      end
    end
  end

  // State register. The step history keeps tracking the input in every mode
  // so entering STEP with the button already held does not fire a tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      div_active <= DEFAULT_DIV;
      div_shadow <= DEFAULT_DIV;
      mode       <= RESET_MODE;
      step_q     <= 1'b0;
      tick       <= 1'b0;
      square     <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      div_active <= div_active_next;
      div_shadow <= div_shadow_next;
      mode       <= mode_next;
      step_q     <= step;
      tick       <= tick_next;
      square     <= square ^ tick_next;
    end
  end

  assign running = (mode == MODE_RUN);

endmodule

// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
// Multi-channel programmable clock-enable generator in the single i_clk domain.
// Ports:
//   i_clk, i_rst_n   system clock, synchronous active-low reset
//   i_wr_en          config write strobe (one cycle)
//   i_wr_ch          channel addressed by the write; out-of-range is ignored
//   i_wr_sel         0 = divisor write, 1 = mode write
//   i_wr_data        divisor value, or mode in [1:0]
//   i_step           per-channel step request (pre-synchronised)
//   o_tick           per-channel one-cycle enable strobe
//   o_square         per-channel 50% square wave, toggling on each tick
//   o_running        per-channel RUN indicator
// -----------------------------------------------------------------------------
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int                   NUM_CH      = 2,
  parameter int                   DIV_WIDTH   = 32,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(8_000_000),
  parameter mode_t                RESET_MODE  = MODE_RUN
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [ch_width(NUM_CH)-1:0]   i_wr_ch,
  input  logic                          i_wr_sel,
  input  logic [DIV_WIDTH-1:0]          i_wr_data,
  input  logic [NUM_CH-1:0]             i_step,
  output logic [NUM_CH-1:0]             o_tick,
  output logic [NUM_CH-1:0]             o_square,
  output logic [NUM_CH-1:0]             o_running
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] ch_wr_en;

  // An address that matches no generated channel enables nothing, so writes
  // beyond NUM_CH fall away without touching any state.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_wr_en[g] = i_wr_en && (i_wr_ch == CH_W'(g));

    clk_div_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV),
      .RESET_MODE  (RESET_MODE)
    ) u_ch (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .wr_en   (ch_wr_en[g]),
      .wr_sel  (i_wr_sel),
      .wr_data (i_wr_data),
      .step    (i_step[g]),
      .tick    (o_tick[g]),
      .square  (o_square[g]),
      .running (o_running[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
// Self-checking bench for clk_enable_gen with three channels and a default
// divisor of 4. A timestamp-based reference model pushes the expected outputs
// for every edge into a queue; they are popped and compared after the edge.
// Hand-written sequences add fixed tick-pattern checks for the corner cases,
// and a vector table exercises mode/decode writes.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;
  import clk_gen_pkg::*;

  localparam int NCH = 3;
  localparam int DEF = 4;

  logic        clock;
  logic        rstN;
  logic        wrEn;
  logic [1:0]  wrCh;
  logic        wrSel;
  logic [31:0] wrData;
  logic [2:0]  stepIn;
  logic [2:0]  tickOut;
  logic [2:0]  squareOut;
  logic [2:0]  runningOut;

  clk_enable_gen #(
    .NUM_CH      (NCH),
    .DIV_WIDTH   (32),
    .DEFAULT_DIV (32'(DEF)),
    .RESET_MODE  (MODE_RUN)
  ) dut (
    .i_clk     (clock),
    .i_rst_n   (rstN),
    .i_wr_en   (wrEn),
    .i_wr_ch   (wrCh),
    .i_wr_sel  (wrSel),
    .i_wr_data (wrData),
    .i_step    (stepIn),
    .o_tick    (tickOut),
    .o_square  (squareOut),
    .o_running (runningOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] tick;
    logic [2:0] square;
    logic [2:0] running;
  } exp_t;

  typedef struct {
    logic [1:0]  ch;
    logic        sel;
    logic [31:0] data;
    logic [2:0]  expRunning;
  } vec_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          edgeNum = 0;

  logic [1:0]  mMode[NCH];
  int unsigned mDiv[NCH];
  int unsigned mShadow[NCH];
  bit          mPend[NCH];
  int          mNext[NCH];
  bit          mSq[NCH];
  bit          mStepQ[NCH];

  logic [2:0]  hist[64];
  int          histLen = 0;

  function automatic int eff(input int unsigned d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, edgeNum, act, exp);
    end
  endtask

  // Reference model for the edge about to occur: ticks are predicted from the
  // edge number of the next wrap rather than from a counter.
  task automatic modelEdge();
    exp_t e;
    bit   t;
    bit   we;
    edgeNum++;
    for (int c = 0; c < NCH; c++) begin
      we = wrEn && (wrCh == 2'(c));
      t  = 1'b0;
      if (!rstN) begin
        mMode[c] = MODE_RUN; mDiv[c] = DEF; mShadow[c] = DEF; mPend[c] = 0;
        mSq[c] = 0; mStepQ[c] = 0; mNext[c] = edgeNum + DEF;
      end else begin
        if (mMode[c] == MODE_RUN) begin
          if (edgeNum == mNext[c]) begin
            t = 1'b1;
            if (we && wrSel == WR_SEL_DIV) mDiv[c] = wrData;
            else if (mPend[c]) mDiv[c] = mShadow[c];
            mPend[c] = 0;
            mNext[c] = edgeNum + eff(mDiv[c]);
          end
        end else if (mMode[c] == MODE_STEP) begin
          t = stepIn[c] && !mStepQ[c];
        end
        if (we && wrSel == WR_SEL_DIV) begin
          mShadow[c] = wrData;
          if (mMode[c] == MODE_RUN) begin
            if (!t) mPend[c] = 1;
          end else begin
            mDiv[c] = wrData; mPend[c] = 0;
          end
        end
        if (we && wrSel == WR_SEL_MODE && wrData[1:0] != mMode[c]) begin
          if (wrData[1:0] == MODE_HALT || wrData[1:0] == MODE_RSVD) t = 1'b0;
          mMode[c] = wrData[1:0];
          if (mMode[c] == MODE_RUN) mNext[c] = edgeNum + eff(mDiv[c]);
        end
        mStepQ[c] = stepIn[c];
        mSq[c]    = mSq[c] ^ t;
      end
      e.tick[c]    = t;
      e.square[c]  = mSq[c];
      e.running[c] = (mMode[c] == MODE_RUN);
    end
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [1:0] ch,
                               input logic sel, input logic [31:0] d, input logic [2:0] st);
    rstN = r; wrEn = we; wrCh = ch; wrSel = sel; wrData = d; stepIn = st;
    modelEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = expQ.pop_front();
      checkVal("tick", 32'(tickOut), 32'(e.tick));
      checkVal("square", 32'(squareOut), 32'(e.square));
      checkVal("running", 32'(runningOut), 32'(e.running));
    end
    if (histLen < 64) begin
      hist[histLen] = tickOut;
      histLen++;
    end
  endtask

  task automatic cycle(input logic r, input logic we, input logic [1:0] ch,
                       input logic sel, input logic [31:0] d, input logic [2:0] st);
    applyStimulus(r, we, ch, sel, d, st);
    checkOutput();
  endtask

  task automatic idle(input int n, input logic [2:0] st = 3'b000);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0, 1'b0, 32'd0, st);
  endtask

  task automatic startCapture();
    histLen = 0;
  endtask

  // Compare the captured ticks of one channel (bit i = i-th captured cycle).
  task automatic checkPattern(input string name, input int c, input int len, input logic [31:0] exp);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < len; i++) p[i] = hist[i][c];
    checkVal(name, p, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    bit   found;

    vecs[0] = '{2'd2, WR_SEL_MODE, 32'(MODE_HALT), 3'b011};
    vecs[1] = '{2'd2, WR_SEL_DIV,  32'd2,          3'b011};
    vecs[2] = '{2'd0, WR_SEL_MODE, 32'(MODE_STEP), 3'b010};
    vecs[3] = '{2'd1, WR_SEL_MODE, 32'(MODE_RSVD), 3'b000};
    vecs[4] = '{2'd3, WR_SEL_MODE, 32'(MODE_RUN),  3'b000};
    vecs[5] = '{2'd1, WR_SEL_MODE, 32'(MODE_RUN),  3'b010};
    vecs[6] = '{2'd1, WR_SEL_MODE, 32'(MODE_RUN),  3'b010};
    vecs[7] = '{2'd0, WR_SEL_MODE, 32'(MODE_RUN),  3'b011};
    vecs[8] = '{2'd2, WR_SEL_MODE, 32'(MODE_RUN),  3'b111};
    vecs[9] = '{2'd0, WR_SEL_DIV,  32'd5,          3'b111};

    rstN = 1'b0; wrEn = 1'b0; wrCh = '0; wrSel = 1'b0; wrData = '0; stepIn = '0;
    #1;

    // Reset, then free-run at the default divisor: ticks 4, 8, 12 edges later.
    $display("[TB] reset and default divisor");
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 3'b000);
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 3'b000);
    checkVal("reset_tick", 32'(tickOut), 32'd0);
    checkVal("reset_running", 32'(runningOut), 32'h7);
    startCapture();
    idle(12);
    for (int c = 0; c < NCH; c++) checkPattern("default_ticks", c, 12, 32'h0888);

    // Divisor 2 written while the counter is 1: period of 4 completes first.
    $display("[TB] shadow divisor write");
    idle(1);
    startCapture();
    cycle(1'b1, 1'b1, 2'd0, WR_SEL_DIV, 32'd2, 3'b000);
    idle(8);
    checkPattern("shadow_ch0", 0, 9, 32'h0154);
    checkPattern("shadow_ch1", 1, 9, 32'h0044);

    // Divisor 0 then 1: a tick every cycle.
    $display("[TB] divisor 0 and 1");
    startCapture();
    cycle(1'b1, 1'b1, 2'd0, WR_SEL_DIV, 32'd0, 3'b000);
    idle(3);
    cycle(1'b1, 1'b1, 2'd0, WR_SEL_DIV, 32'd1, 3'b000);
    idle(4);
    checkPattern("div01_ch0", 0, 9, 32'h01FE);

    // STEP mode: held step gives one tick, then two pulses give one each.
    $display("[TB] step mode");
    cycle(1'b1, 1'b1, 2'd0, WR_SEL_MODE, 32'(MODE_STEP), 3'b000);
    startCapture();
    idle(10, 3'b111);
    idle(2);
    idle(1, 3'b111);
    idle(1);
    idle(1, 3'b111);
    idle(2);
    checkPattern("step_ch0", 0, 17, 32'h5001);

    // HALT channel 1 while its square output is high.
    $display("[TB] halt and rerun");
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      idle(1);
      if (tickOut[1] && squareOut[1]) found = 1'b1;
    end
    checkVal("wait_square_high", 32'(found), 32'd1);
    idle(1);
    startCapture();
    cycle(1'b1, 1'b1, 2'd1, WR_SEL_MODE, 32'(MODE_HALT), 3'b000);
    idle(10);
    checkPattern("halt_ch1", 1, 11, 32'h0);
    checkVal("halt_square", 32'(squareOut[1]), 32'd1);
    cycle(1'b1, 1'b1, 2'd1, WR_SEL_DIV, 32'd3, 3'b000);
    cycle(1'b1, 1'b1, 2'd1, WR_SEL_MODE, 32'(MODE_RUN), 3'b000);
    startCapture();
    idle(7);
    checkPattern("rerun_ch1", 1, 7, 32'h0024);

    // Reset on the edge that would produce channel 1's next tick.
    $display("[TB] reset before tick and invalid channel");
    idle(1);
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 3'b000);
    checkVal("abort_tick", 32'(tickOut), 32'd0);
    checkVal("abort_square", 32'(squareOut), 32'd0);
    startCapture();
    cycle(1'b1, 1'b1, 2'd3, WR_SEL_DIV, 32'd1, 3'b000);
    cycle(1'b1, 1'b1, 2'd3, WR_SEL_MODE, 32'(MODE_HALT), 3'b000);
    idle(10);
    for (int c = 0; c < NCH; c++) checkPattern("invalid_ch", c, 12, 32'h0888);
    checkVal("invalid_running", 32'(runningOut), 32'h7);

    // Mode and decode vectors.
    $display("[TB] mode vector table");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, vecs[i].ch, vecs[i].sel, vecs[i].data, 3'b000);
      checkVal("vec_running", 32'(runningOut), 32'(vecs[i].expRunning));
    end
    idle(24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
